// File: rtl/elbeth_mem_arbiter_pkg.sv
// Shared types and constants for the elbeth memory arbiter.
// FSM encoding, priority reset value and default timeout.
package elbeth_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_t;

  localparam logic PRIO_RST    = 1'b0;
  localparam int   TIMEOUT_DEF = 15;
  localparam int   CNT_W       = 8;

endpackage

// File: rtl/elbeth_mem_arbiter_rr_prio.sv
// Two-request round-robin pick with its priority register.
// prio only matters on a tie; it flips away from each granted master.
module elbeth_mem_arbiter_rr_prio
  import elbeth_mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       take,
  output logic       gnt
);

  logic prio;

  always_comb begin
    gnt = 1'b0;
    unique case (1'b1)
      (req == 2'b11): gnt = prio;
      (req == 2'b10): gnt = 1'b1;
      default:        gnt = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio <= PRIO_RST;
    end else if (take) begin
      prio <= ~gnt;
    end
  end

endmodule

// File: rtl/elbeth_mem_arbiter.sv
// Shares one memory port between the core data path and a debug/DMA
// master: one access per grant, single enable pulse, bounded wait.
module elbeth_mem_arbiter
  import elbeth_mem_arbiter_pkg::*;
#(
  parameter int AW      = 8,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_enable,
  input  logic [AW-1:0] m0_addr,
  input  logic [31:0]   m0_data_in,
  input  logic [3:0]    m0_wr,
  output logic [31:0]   m0_data_out,
  output logic          m0_ready,
  output logic          m0_error,
  input  logic          m1_enable,
  input  logic [AW-1:0] m1_addr,
  input  logic [31:0]   m1_data_in,
  input  logic [3:0]    m1_wr,
  output logic [31:0]   m1_data_out,
  output logic          m1_ready,
  output logic          m1_error,
  output logic          mem_enable,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_data_in,
  output logic [3:0]    mem_wr,
  input  logic [31:0]   mem_data_out,
  input  logic          mem_ready
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_t       state, state_n;
  logic             gnt, gnt_q;
  logic [AW-1:0]    addr_q;
  logic [31:0]      data_q;
  logic [3:0]       wr_q;
  logic [CNT_W-1:0] cnt;
  logic             take, hit, expire;

  assign take   = (state == ST_IDLE) && (m0_enable || m1_enable);
  assign hit    = (state == ST_WAIT) && mem_ready;
  assign expire = (state == ST_WAIT) && !mem_ready && (cnt == CNT_LAST);

  elbeth_mem_arbiter_rr_prio u_rr (
    .clk  (clk),
    .rst  (rst),
    .req  ({m1_enable, m0_enable}),
    .take (take),
    .gnt  (gnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE:  if (take) state_n = ST_ISSUE;
      ST_ISSUE: state_n = ST_WAIT;
      ST_WAIT:  if (hit || expire) state_n = ST_DONE;
      ST_DONE:  state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q       <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      wr_q        <= '0;
      cnt         <= '0;
      m0_data_out <= '0;
      m0_error    <= 1'b0;
      m1_data_out <= '0;
      m1_error    <= 1'b0;
    end else begin
      if (take) begin
        gnt_q  <= gnt;
        addr_q <= gnt ? m1_addr : m0_addr;
        data_q <= gnt ? m1_data_in : m0_data_in;
        wr_q   <= gnt ? m1_wr : m0_wr;
        cnt    <= '0;
      end
      if ((state == ST_WAIT) && !hit && !expire) begin
        cnt <= cnt + 1'b1;
      end
      // a timed-out access reports zero data alongside the error
      if (hit || expire) begin
        if (gnt_q) begin
          m1_data_out <= hit ? mem_data_out : 32'h0;
          m1_error    <= expire;
        end else begin
          m0_data_out <= hit ? mem_data_out : 32'h0;
          m0_error    <= expire;
        end
      end
    end
  end

  assign mem_enable  = (state == ST_ISSUE);
  assign mem_wr      = mem_enable ? wr_q : 4'h0;
  assign mem_addr    = addr_q;
  assign mem_data_in = data_q;
  assign m0_ready    = (state == ST_DONE) && !gnt_q;
  assign m1_ready    = (state == ST_DONE) && gnt_q;

endmodule
